// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// start/busy/valid handshake; saturates to all nines and flags ovf when bin exceeds DIGITS.
module bin_to_bcd_seq #(
  parameter int W      = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [W-1:0]          bin,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int SW = 4 * (DIGITS + 1);  // scratch width, includes one guard nibble
  localparam int CW = $clog2(W + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [SW-1:0]  scratch;
  logic [W-1:0]   bin_sh;
  logic [CW-1:0]  count;
  logic           sticky;

  logic [SW-1:0]   adj;
  logic [SW+W:0]   shifted;
  logic [SW-1:0]   nscr;
  logic [W-1:0]    nbin;
  logic            carry;
  logic            ovf_now;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    adj = scratch;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (scratch[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
    end
    shifted = {1'b0, adj, bin_sh} << 1;
    carry   = shifted[SW+W];
    nscr    = shifted[SW+W-1:W];
    nbin    = shifted[W-1:0];
    // Any bit that reaches or passes the guard nibble means the value needs DIGITS+1 digits.
    ovf_now = sticky | carry | (nscr[SW-1 -: 4] != 4'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      scratch <= '0;
      bin_sh  <= '0;
      count   <= '0;
      sticky  <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      bcd     <= '0;
      ovf     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sh  <= bin;
            scratch <= '0;
            sticky  <= 1'b0;
            count   <= CW'(W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= nscr;
          bin_sh  <= nbin;
          sticky  <= sticky | carry;
          count   <= count - 1'b1;
          if (count == CW'(1)) begin
            bcd   <= ovf_now ? {DIGITS{4'h9}} : nscr[4*DIGITS-1:0];
            ovf   <= ovf_now;
            valid <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: an 8-bit and a 10-bit instance, both with 3 digits,
// checked against a decimal reference model, vector tables and handshake corner sequences.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start8 = 1'b0, start10 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic [9:0]  bin10 = '0;
  logic        busy8, valid8, ovf8, busy10, valid10, ovf10;
  logic [11:0] bcd8, bcd10;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.W(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .start(start8), .bin(bin8),
    .busy(busy8), .valid(valid8), .bcd(bcd8), .ovf(ovf8)
  );

  bin_to_bcd_seq #(.W(10), .DIGITS(3)) u10 (
    .clk(clk), .rst(rst), .start(start10), .bin(bin10),
    .busy(busy10), .valid(valid10), .bcd(bcd10), .ovf(ovf10)
  );

  typedef struct {
    bit          wide;
    int          bin;
    logic [11:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Decimal reference: three digits, saturating to 999 with overflow above that.
  task automatic ref_bcd(input int v, output logic [11:0] b, output logic o);
    int r;
    o = (v > 999);
    r = o ? 999 : v;
    b = {4'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
  endtask

  function automatic logic get_valid(input bit wide);
    return wide ? valid10 : valid8;
  endfunction

  function automatic logic get_busy(input bit wide);
    return wide ? busy10 : busy8;
  endfunction

  // Edges from the accepting edge (counted as 1) until valid is seen, plus busy cycles seen.
  task automatic wait_valid(input bit wide, output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (!get_valid(wide) && lat < 60) begin
      if (get_busy(wide)) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input bit wide, input int v, input logic [11:0] eb, input logic eo,
                     input string nm);
    int lat, bc;
    @(negedge clk);
    if (wide) begin bin10 = v[9:0]; start10 = 1'b1; end
    else      begin bin8  = v[7:0]; start8  = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start10 = 1'b0;
    bin8 = 8'hA5; bin10 = 10'h2A5;
    wait_valid(wide, lat, bc);
    check({nm, " latency"}, lat, wide ? 11 : 9);
    check({nm, " busy_cycles"}, bc, wide ? 10 : 8);
    check({nm, " bcd"}, wide ? bcd10 : bcd8, eb);
    check({nm, " ovf"}, wide ? ovf10 : ovf8, eo);
    check({nm, " busy_at_valid"}, get_busy(wide), 1'b0);
  endtask

  task automatic run_model(input bit wide, input int v, input string nm);
    logic [11:0] eb;
    logic eo;
    ref_bcd(v, eb, eo);
    run(wide, v, eb, eo, nm);
  endtask

  initial begin
    vec_t tbl[$];
    int lat, bc, pulses, first_i;
    logic [11:0] cap;

    tbl.push_back('{0, 255,  12'h255, 1'b0});
    tbl.push_back('{0, 99,   12'h099, 1'b0});
    tbl.push_back('{0, 7,    12'h007, 1'b0});
    tbl.push_back('{0, 100,  12'h100, 1'b0});
    tbl.push_back('{1, 999,  12'h999, 1'b0});
    tbl.push_back('{1, 1000, 12'h999, 1'b1});
    tbl.push_back('{1, 1023, 12'h999, 1'b1});
    tbl.push_back('{1, 512,  12'h512, 1'b0});

    // Reset state
    #2 rst = 1'b1;
    #10;
    check("reset busy8", busy8, 1'b0);
    check("reset valid8", valid8, 1'b0);
    check("reset bcd8", bcd8, 12'h000);
    check("reset ovf8", ovf8, 1'b0);
    check("reset busy10", busy10, 1'b0);
    check("reset bcd10", bcd10, 12'h000);
    @(negedge clk) rst = 1'b0;

    // Zero conversion, then valid must be a one-cycle pulse
    run(0, 0, 12'h000, 1'b0, "zero");
    @(posedge clk); #1;
    check("valid_one_cycle", valid8, 1'b0);

    foreach (tbl[i]) run(tbl[i].wide, tbl[i].bin, tbl[i].bcd, tbl[i].ovf, $sformatf("tbl%0d", i));

    // Full sweep of the 8-bit instance, then random values on both
    for (int v = 0; v < 256; v++) run_model(0, v, $sformatf("sweep%0d", v));
    for (int i = 0; i < 20; i++) run_model(0, int'($urandom_range(0, 255)), "rand8");
    for (int i = 0; i < 40; i++) run_model(1, int'($urandom_range(0, 1023)), "rand10");

    // Start while busy is ignored
    @(negedge clk); bin8 = 8'd200; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; bin8 = 8'd0;
    pulses = 0; first_i = 0; cap = '0;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i == 3) begin start8 = 1'b1; bin8 = 8'd42; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      if (valid8) begin
        if (pulses == 0) begin first_i = i; cap = bcd8; end
        pulses++;
      end
    end
    check("busy_start valid_pulses", pulses, 1);
    check("busy_start valid_edge", first_i, 8);
    check("busy_start bcd", cap, 12'h200);

    // Start accepted in the valid cycle: back-to-back conversions
    run(0, 128, 12'h128, 1'b0, "b2b_first");
    bin8 = 8'd64; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0; bin8 = 8'd0;
    wait_valid(0, lat, bc);
    check("b2b_second latency", lat, 9);
    check("b2b_second bcd", bcd8, 12'h064);

    // Asynchronous reset mid-conversion
    @(negedge clk); bin8 = 8'd150; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst busy", busy8, 1'b0);
    check("midrst valid", valid8, 1'b0);
    check("midrst bcd", bcd8, 12'h000);
    check("midrst ovf", ovf8, 1'b0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (valid8) pulses++;
    end
    check("midrst stale_valid", pulses, 0);
    run(0, 150, 12'h150, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
